// File: rtl/lsu_ctrl_if.sv
// Request, data-memory bus and writeback response signals of the load/store unit.
// The slave modport is the lsu_ctrl view; the master modport is the environment.
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic        req_rd;
    logic [2:0]  req_memop;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wmask;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // Handshakes: a request transfers on a clock edge where req_valid && req_ready.
    // bus_req is held with stable bus_we/addr/wmask/wdata until the edge where
    // bus_ack is high. rsp_valid is a single-cycle pulse with no back-pressure.
    modport slave (
        input  req_valid, req_wr, req_rd, req_memop, req_addr, req_wdata,
        output req_ready,
        output bus_req, bus_we, bus_addr, bus_wmask, bus_wdata,
        input  bus_ack, bus_rdata,
        output rsp_valid, rsp_rdata, rsp_err
    );

    modport master (
        output req_valid, req_wr, req_rd, req_memop, req_addr, req_wdata,
        input  req_ready,
        input  bus_req, bus_we, bus_addr, bus_wmask, bus_wdata,
        output bus_ack, bus_rdata,
        input  rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit: one outstanding word-aligned data-memory transaction with byte
// lanes, load extension, misalign/illegal-op detection and a bus timeout.
module lsu_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    lsu_ctrl_if.slave   lsu,
    output logic [1:0]  o_dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_op;
    logic [1:0]    r_lane;
    logic          r_is_ld;

    logic          r_bus_req;
    logic          r_bus_we;
    logic [31:0]   r_bus_addr;
    logic [3:0]    r_bus_wmask;
    logic [31:0]   r_bus_wdata;
    logic          r_rsp_valid;
    logic [31:0]   r_rsp_rdata;
    logic          r_rsp_err;

    logic          w_is_st;
    logic          w_is_ld;
    logic          w_noop;
    logic          w_half;
    logic          w_word;
    logic          w_misal;
    logic          w_st_ill;
    logic          w_ld_ill;
    logic          w_err;
    logic [3:0]    w_mask;
    logic [31:0]   w_wdata;
    logic [31:0]   w_shift;
    logic [31:0]   w_load;
    logic          w_timeout;

    // A request with both req_wr and req_rd is a store.
    assign w_is_st = lsu.req_wr;
    assign w_is_ld = lsu.req_rd & ~lsu.req_wr;
    assign w_noop  = ~lsu.req_wr & ~lsu.req_rd;

    assign w_half   = (lsu.req_memop[1:0] == 2'b01);
    assign w_word   = (lsu.req_memop[1:0] == 2'b10);
    assign w_misal  = (w_half & lsu.req_addr[0]) | (w_word & (|lsu.req_addr[1:0]));
    assign w_st_ill = lsu.req_memop[2] | (lsu.req_memop[1:0] == 2'b11);
    assign w_ld_ill = (lsu.req_memop[1:0] == 2'b11) | (lsu.req_memop[2:1] == 2'b11);
    assign w_err    = (w_is_st & (w_st_ill | w_misal)) | (w_is_ld & (w_ld_ill | w_misal));

    always_comb begin
        w_mask  = 4'b1111;
        w_wdata = lsu.req_wdata;
        case (lsu.req_memop[1:0])
            2'b00: begin
                w_mask  = 4'b0001 << lsu.req_addr[1:0];
                w_wdata = {4{lsu.req_wdata[7:0]}};
            end
            2'b01: begin
                w_mask  = lsu.req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{lsu.req_wdata[15:0]}};
            end
            default: begin
                w_mask  = 4'b1111;
                w_wdata = lsu.req_wdata;
            end
        endcase
    end

    // Bring the addressed byte/half down to bit 0 before extension.
    assign w_shift = lsu.bus_rdata >> {r_lane, 3'b000};

    always_comb begin
        w_load = w_shift;
        case (r_op)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_load = {24'd0, w_shift[7:0]};
            3'b101:  w_load = {16'd0, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_op        <= 3'd0;
            r_lane      <= 2'd0;
            r_is_ld     <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_wmask <= 4'd0;
            r_bus_wdata <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (lsu.req_valid) begin
                        r_op    <= lsu.req_memop;
                        r_lane  <= lsu.req_addr[1:0];
                        r_is_ld <= w_is_ld;
                        r_cnt   <= '0;
                        if (w_noop || w_err) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= w_err;
                            r_rsp_rdata <= 32'd0;
                        end else begin
                            r_state     <= S_BUS;
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= w_is_st;
                            r_bus_addr  <= {lsu.req_addr[31:2], 2'b00};
                            r_bus_wmask <= w_is_st ? w_mask : 4'd0;
                            r_bus_wdata <= w_is_st ? w_wdata : 32'd0;
                        end
                    end
                end
                S_BUS: begin
                    // An ack in the timeout cycle still completes the transfer.
                    if (lsu.bus_ack) begin
                        r_state     <= S_RESP;
                        r_bus_req   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= r_is_ld ? w_load : 32'd0;
                    end else if (w_timeout) begin
                        r_state     <= S_RESP;
                        r_bus_req   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= 32'd0;
                    end else if (TIMEOUT != 0) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= 32'd0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign lsu.req_ready = (r_state == S_IDLE);
    assign lsu.bus_req   = r_bus_req;
    assign lsu.bus_we    = r_bus_we;
    assign lsu.bus_addr  = r_bus_addr;
    assign lsu.bus_wmask = r_bus_wmask;
    assign lsu.bus_wdata = r_bus_wdata;
    assign lsu.rsp_valid = r_rsp_valid;
    assign lsu.rsp_rdata = r_rsp_rdata;
    assign lsu.rsp_err   = r_rsp_err;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl (TIMEOUT=4): stores, loads with extension,
// misaligned/illegal/no-op requests, bus timeout and reset during a transfer.
module tb_lsu_ctrl;

    logic       clk;
    logic       rstn;
    logic [1:0] dbg_state;
    int         n_checks;
    int         n_pass;
    int         n_rsp;

    lsu_ctrl_if lsu ();

    lsu_ctrl #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .lsu         (lsu),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts response pulses, sampled mid-cycle.
    always @(negedge clk) if (lsu.rsp_valid === 1'b1) n_rsp++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string tag, input logic wr, input logic rd, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata);
        lsu.req_valid = 1'b1;
        lsu.req_wr    = wr;
        lsu.req_rd    = rd;
        lsu.req_memop = op;
        lsu.req_addr  = addr;
        lsu.req_wdata = wdata;
        check({tag, "_ready_c0"}, 32'(lsu.req_ready), 32'd1);
        tick();
        lsu.req_valid = 1'b0;
    endtask

    // Called in the rsp_valid cycle; returns one cycle later.
    task automatic expect_resp(input string tag, input logic err, input logic [31:0] rdata);
        check({tag, "_rsp_valid"}, 32'(lsu.rsp_valid), 32'd1);
        check({tag, "_rsp_err"}, 32'(lsu.rsp_err), 32'(err));
        check({tag, "_rsp_rdata"}, lsu.rsp_rdata, rdata);
        check({tag, "_ready_rsp"}, 32'(lsu.req_ready), 32'd0);
        tick();
        check({tag, "_rsp_drop"}, 32'(lsu.rsp_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(lsu.req_ready), 32'd1);
    endtask

    task automatic xfer(input string tag, input logic wr, input logic rd, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata, input int ack_k,
                        input logic [31:0] rdata, input logic [31:0] e_addr,
                        input logic [3:0] e_mask, input logic [31:0] e_wdata,
                        input logic [31:0] e_rdata);
        issue(tag, wr, rd, op, addr, wdata);
        check({tag, "_bus_addr"}, lsu.bus_addr, e_addr);
        check({tag, "_bus_we"}, 32'(lsu.bus_we), 32'(wr));
        check({tag, "_bus_wmask"}, 32'(lsu.bus_wmask), 32'(e_mask));
        if (wr) check({tag, "_bus_wdata"}, lsu.bus_wdata, e_wdata);
        for (int c = 1; c <= ack_k; c++) begin
            check({tag, "_bus_req"}, 32'(lsu.bus_req), 32'd1);
            check({tag, "_ready_busy"}, 32'(lsu.req_ready), 32'd0);
            if (c == ack_k) begin
                lsu.bus_ack   = 1'b1;
                lsu.bus_rdata = rdata;
            end
            tick();
        end
        lsu.bus_ack   = 1'b0;
        lsu.bus_rdata = 32'd0;
        check({tag, "_bus_req_drop"}, 32'(lsu.bus_req), 32'd0);
        expect_resp(tag, 1'b0, e_rdata);
    endtask

    task automatic no_bus(input string tag, input logic wr, input logic rd, input logic [2:0] op,
                          input logic [31:0] addr, input logic err);
        issue(tag, wr, rd, op, addr, 32'hFFFF_FFFF);
        check({tag, "_no_bus_req"}, 32'(lsu.bus_req), 32'd0);
        expect_resp(tag, err, 32'd0);
    endtask

    int n_before;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_rsp    = 0;
        rstn          = 1'b0;
        lsu.req_valid = 1'b0;
        lsu.req_wr    = 1'b0;
        lsu.req_rd    = 1'b0;
        lsu.req_memop = 3'd0;
        lsu.req_addr  = 32'd0;
        lsu.req_wdata = 32'd0;
        lsu.bus_ack   = 1'b0;
        lsu.bus_rdata = 32'd0;

        tick();
        tick();
        check("rst_ready", 32'(lsu.req_ready), 32'd1);
        check("rst_bus_req", 32'(lsu.bus_req), 32'd0);
        check("rst_bus_we", 32'(lsu.bus_we), 32'd0);
        check("rst_bus_addr", lsu.bus_addr, 32'd0);
        check("rst_bus_wmask", 32'(lsu.bus_wmask), 32'd0);
        check("rst_bus_wdata", lsu.bus_wdata, 32'd0);
        check("rst_rsp_valid", 32'(lsu.rsp_valid), 32'd0);
        check("rst_rsp_rdata", lsu.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(lsu.rsp_err), 32'd0);
        rstn = 1'b1;
        tick();

        // Stores
        xfer("sw", 1, 0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1, 32'h0,
             32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        xfer("sb", 1, 0, 3'b000, 32'h0000_0203, 32'h1234_565A, 1, 32'h0,
             32'h0000_0200, 4'b1000, 32'h5A5A_5A5A, 32'h0);
        xfer("sh", 1, 0, 3'b001, 32'h0000_0102, 32'hAAAA_BEEF, 2, 32'h0,
             32'h0000_0100, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        xfer("sw_rdwr", 1, 1, 3'b010, 32'h0000_0108, 32'h0BAD_F00D, 1, 32'hFFFF_FFFF,
             32'h0000_0108, 4'b1111, 32'h0BAD_F00D, 32'h0);

        // Loads; ack in cycle 4 also coincides with the last timeout cycle
        xfer("lb", 0, 1, 3'b000, 32'h0000_0301, 32'h0, 4, 32'h0000_F000,
             32'h0000_0300, 4'b0000, 32'h0, 32'hFFFF_FFF0);
        xfer("lbu", 0, 1, 3'b100, 32'h0000_0301, 32'h0, 4, 32'h0000_F000,
             32'h0000_0300, 4'b0000, 32'h0, 32'h0000_00F0);
        xfer("lh", 0, 1, 3'b001, 32'h0000_0302, 32'h0, 1, 32'h8001_0000,
             32'h0000_0300, 4'b0000, 32'h0, 32'hFFFF_8001);
        xfer("lhu", 0, 1, 3'b101, 32'h0000_0302, 32'h0, 2, 32'h8001_0000,
             32'h0000_0300, 4'b0000, 32'h0, 32'h0000_8001);
        xfer("lw", 0, 1, 3'b010, 32'h0000_0304, 32'h0, 1, 32'h1234_5678,
             32'h0000_0304, 4'b0000, 32'h0, 32'h1234_5678);
        xfer("lb_pos", 0, 1, 3'b000, 32'h0000_0300, 32'h0, 1, 32'hFFFF_FF7F,
             32'h0000_0300, 4'b0000, 32'h0, 32'h0000_007F);

        // Errors and no-op: response in cycle 1, no bus activity
        no_bus("lw_mis", 0, 1, 3'b010, 32'h0000_0102, 1);
        no_bus("lh_mis", 0, 1, 3'b001, 32'h0000_0101, 1);
        no_bus("sw_mis", 1, 0, 3'b010, 32'h0000_0101, 1);
        no_bus("st_ill", 1, 0, 3'b100, 32'h0000_0100, 1);
        no_bus("ld_ill", 0, 1, 3'b011, 32'h0000_0100, 1);
        no_bus("ld_ill7", 0, 1, 3'b111, 32'h0000_0100, 1);
        no_bus("noop", 0, 0, 3'b010, 32'h0000_0101, 0);

        // Timeout: bus_req in cycles 1..4, error response in cycle 5
        issue("tmo", 0, 1, 3'b010, 32'h0000_0400, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            check("tmo_bus_req", 32'(lsu.bus_req), 32'd1);
            tick();
        end
        check("tmo_bus_req_drop", 32'(lsu.bus_req), 32'd0);
        expect_resp("tmo", 1'b1, 32'd0);

        // Reset in the middle of a bus transfer
        issue("rst_mid", 0, 1, 3'b010, 32'h0000_0500, 32'h0);
        check("rst_mid_bus_req", 32'(lsu.bus_req), 32'd1);
        n_before = n_rsp;
        #3;
        rstn = 1'b0;
        #1;
        check("rst_mid_async_drop", 32'(lsu.bus_req), 32'd0);
        tick();
        tick();
        rstn = 1'b1;
        tick();
        check("rst_mid_no_rsp", 32'(n_rsp), 32'(n_before));
        check("rst_mid_ready", 32'(lsu.req_ready), 32'd1);
        xfer("lhu_after", 0, 1, 3'b101, 32'h0000_0502, 32'h0, 1, 32'hBEEF_0000,
             32'h0000_0500, 4'b0000, 32'h0, 32'h0000_BEEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
